// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI request round-robin arbiter.
//   arb_state_e : arbiter FSM states
//   CMD_W       : width of a spi_master command code
//   rr_pick     : first set request bit at or above ptr, wrapping (up to 8 requesters)
package spi_arb_pkg;

  localparam int unsigned CMD_W     = 3;
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Rotate so that bit ptr lands at position 0, priority-encode, then rotate the
  // index back. Unused upper request bits must be zero, so wrapping at 8 is
  // equivalent to wrapping at the real requester count.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                   input logic [MAX_IDX_W-1:0] ptr);
    logic [2*MAX_REQ-1:0] dbl;
    logic [MAX_REQ-1:0]   rot;
    logic [MAX_IDX_W-1:0] idx;
    dbl = {req, req} >> ptr;
    rot = dbl[MAX_REQ-1:0];
    idx = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = MAX_IDX_W'(k) + ptr;
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_req_rr_arbiter_if.sv
// Bundle of the requester-side and spi_master-side signals of the arbiter.
//   s_* : per-requester command/stream signals (slot i at [i*W +: W])
//   m_* : single spi_master request/stream port
// Modports: master = arbiter view (it owns the spi_master port),
//           slave  = surrounding engines + spi_master view.
interface spi_req_rr_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 8,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned LEN_W = 24
);

  logic [NREQ-1:0]       s_request;
  logic [NREQ*LEN_W-1:0] s_req_len;
  logic [NREQ*LEN_W-1:0] s_req_wr_len;
  logic [NREQ*CMD_W-1:0] s_req_cmd;
  logic [NREQ-1:0]       s_busy;
  logic [NREQ-1:0]       s_finish;
  logic [NREQ-1:0]       s_wr_vld;
  logic [NREQ*DSIZE-1:0] s_wr_data;
  logic [NREQ-1:0]       s_wr_ready;
  logic [NREQ-1:0]       s_wr_last;
  logic [NREQ-1:0]       s_rd_ready;
  logic [NREQ-1:0]       s_rd_vld;
  logic [DSIZE-1:0]      s_rd_data;

  logic                  m_request;
  logic [LEN_W-1:0]      m_req_len;
  logic [LEN_W-1:0]      m_req_wr_len;
  logic [CMD_W-1:0]      m_req_cmd;
  logic                  m_busy;
  logic                  m_finish;
  logic                  m_wr_vld;
  logic [DSIZE-1:0]      m_wr_data;
  logic                  m_wr_ready;
  logic                  m_wr_last;
  logic                  m_rd_ready;
  logic                  m_rd_vld;
  logic [DSIZE-1:0]      m_rd_data;

  modport master (
    input  s_request, s_req_len, s_req_wr_len, s_req_cmd, s_wr_vld, s_wr_data, s_rd_ready,
    input  m_busy, m_finish, m_wr_ready, m_wr_last, m_rd_vld, m_rd_data,
    output s_busy, s_finish, s_wr_ready, s_wr_last, s_rd_vld, s_rd_data,
    output m_request, m_req_len, m_req_wr_len, m_req_cmd, m_wr_vld, m_wr_data, m_rd_ready
  );

  modport slave (
    output s_request, s_req_len, s_req_wr_len, s_req_cmd, s_wr_vld, s_wr_data, s_rd_ready,
    output m_busy, m_finish, m_wr_ready, m_wr_last, m_rd_vld, m_rd_data,
    input  s_busy, s_finish, s_wr_ready, s_wr_last, s_rd_vld, s_rd_data,
    input  m_request, m_req_len, m_req_wr_len, m_req_cmd, m_wr_vld, m_wr_data, m_rd_ready
  );

endinterface

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin selector.
//   req     : request vector
//   ptr     : search start position
//   found_c : any request pending
//   idx_c   : first requesting slot at or above ptr, wrapping
module spi_arb_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [MAX_REQ-1:0]   req_ext;
  logic [MAX_IDX_W-1:0] ptr_ext;

  assign req_ext = MAX_REQ'(req);
  assign ptr_ext = MAX_IDX_W'(ptr);
  assign found_c = |req;
  assign idx_c   = IDX_W'(rr_pick(req_ext, ptr_ext));

endmodule

// File: rtl/spi_req_rr_arbiter.sv
// Round-robin arbiter sharing one spi_master request/data port between NREQ
// command engines. Grants one requester at a time, latches its descriptor,
// steers the write/read streams to it and releases on the master's finish.
// Ports:
//   clock, rst_n, clk_en : clock, async active-low reset, advance enable
//   bus (master modport) : s_* requester side, m_* spi_master side
//   arb_err              : sticky watchdog error
// Optional feature: define SPI_ARB_WDOG_EN to enable the grant watchdog
// (TIMEOUT enabled cycles); otherwise arb_err is tied to 0.
module spi_req_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 8,
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned LEN_W   = 24,
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  clk_en,
  spi_req_rr_arbiter_if.master  bus,
  output logic                  arb_err
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner_idx;
  logic [NREQ-1:0]  owner_oh;
  logic [LEN_W-1:0] lat_len;
  logic [LEN_W-1:0] lat_wr_len;
  logic [CMD_W-1:0] lat_cmd;
  logic             m_request_r;
  logic [NREQ-1:0]  s_busy_r;
  logic [NREQ-1:0]  s_finish_r;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] ptr_next;
  logic             data_en;
  logic             wdog_hit;
  logic             go_release;

  spi_arb_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.s_request),
    .ptr     (rr_ptr),
    .found_c (pick_found),
    .idx_c   (pick_idx)
  );

  assign owner_oh   = NREQ'(1) << owner_idx;
  assign ptr_next   = (owner_idx == IDX_W'(NREQ - 1)) ? '0 : owner_idx + IDX_W'(1);
  assign data_en    = (state == ISSUE) || (state == RUN);
  // Finish (even before busy) or a watchdog expiry both end the grant.
  assign go_release = data_en && (bus.m_finish || wdog_hit);

  // Arbitration FSM with registered grant, request and completion outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner_idx   <= '0;
      lat_len     <= '0;
      lat_wr_len  <= '0;
      lat_cmd     <= '0;
      m_request_r <= 1'b0;
      s_busy_r    <= '0;
      s_finish_r  <= '0;
    end else if (clk_en) begin
      if (go_release) begin
        state       <= RELEASE;
        m_request_r <= 1'b0;
        s_busy_r    <= '0;
        s_finish_r  <= owner_oh;
      end else begin
        case (state)
          IDLE: begin
            if (pick_found) begin
              owner_idx   <= pick_idx;
              lat_len     <= bus.s_req_len[pick_idx*LEN_W +: LEN_W];
              lat_wr_len  <= bus.s_req_wr_len[pick_idx*LEN_W +: LEN_W];
              lat_cmd     <= bus.s_req_cmd[pick_idx*CMD_W +: CMD_W];
              s_busy_r    <= NREQ'(1) << pick_idx;
              m_request_r <= 1'b1;
              state       <= ISSUE;
            end
          end
          ISSUE: begin
            if (bus.m_busy) begin
              m_request_r <= 1'b0;
              state       <= RUN;
            end
          end
          RUN: begin
          end
          RELEASE: begin
            s_finish_r <= '0;
            rr_ptr     <= ptr_next;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.m_request    = m_request_r;
  assign bus.m_req_len    = lat_len;
  assign bus.m_req_wr_len = lat_wr_len;
  assign bus.m_req_cmd    = lat_cmd;
  assign bus.s_busy       = s_busy_r;
  assign bus.s_finish     = s_finish_r;

  // Stream steering follows the registered owner; everything is quiet outside ISSUE/RUN.
  assign bus.m_wr_vld   = data_en & bus.s_wr_vld[owner_idx];
  assign bus.m_wr_data  = data_en ? bus.s_wr_data[owner_idx*DSIZE +: DSIZE] : '0;
  assign bus.s_wr_ready = (data_en & bus.m_wr_ready) ? owner_oh : '0;
  assign bus.s_wr_last  = (data_en & bus.m_wr_last)  ? owner_oh : '0;
  assign bus.m_rd_ready = data_en & bus.s_rd_ready[owner_idx];
  assign bus.s_rd_vld   = (data_en & bus.m_rd_vld)   ? owner_oh : '0;
  assign bus.s_rd_data  = data_en ? bus.m_rd_data : '0;

`ifdef SPI_ARB_WDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            arb_err_r;

  assign wdog_hit = data_en && (wdog_cnt == WD_W'(TIMEOUT - 1));

  // Watchdog: restarts on every grant, counts enabled ISSUE/RUN cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt  <= '0;
      arb_err_r <= 1'b0;
    end else if (clk_en) begin
      if ((state == IDLE) && pick_found) begin
        wdog_cnt <= '0;
      end else if (wdog_hit) begin
        wdog_cnt  <= '0;
        arb_err_r <= 1'b1;
      end else if (data_en) begin
        wdog_cnt <= wdog_cnt + WD_W'(1);
      end
    end
  end

  assign arb_err = arb_err_r;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT);
  assign wdog_hit       = 1'b0;
  assign arb_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_req_rr_arbiter.sv
// Self-checking bench for spi_req_rr_arbiter: directed scenarios plus randomized
// transactions compared against a round-robin reference model.
module tb_spi_req_rr_arbiter;
  import spi_arb_pkg::*;

  localparam int unsigned NREQ    = 8;
  localparam int unsigned DSIZE   = 8;
  localparam int unsigned LEN_W   = 24;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic arb_err;

  spi_req_rr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE), .LEN_W(LEN_W)) bus ();

  spi_req_rr_arbiter #(
    .NREQ    (NREQ),
    .DSIZE   (DSIZE),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock   (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .bus     (bus),
    .arb_err (arb_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int               exp_ptr = 0;
  logic [LEN_W-1:0] len_tab    [NREQ];
  logic [LEN_W-1:0] wr_len_tab [NREQ];
  logic [CMD_W-1:0] cmd_tab    [NREQ];
  int               grant_log  [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round robin: first requester at or after ptr, counting upward modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] mask, input int ptr);
    int i;
    for (int k = 0; k < int'(NREQ); k++) begin
      i = (ptr + k) % NREQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < int'(NREQ); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic randomize_descs();
    for (int i = 0; i < int'(NREQ); i++) begin
      len_tab[i]    = LEN_W'($urandom);
      wr_len_tab[i] = LEN_W'($urandom);
      cmd_tab[i]    = CMD_W'($urandom);
      bus.s_req_len[i*LEN_W +: LEN_W]    = len_tab[i];
      bus.s_req_wr_len[i*LEN_W +: LEN_W] = wr_len_tab[i];
      bus.s_req_cmd[i*CMD_W +: CMD_W]    = cmd_tab[i];
    end
  endtask

  task automatic drive_streams();
    bus.s_wr_vld   = NREQ'($urandom);
    bus.s_wr_data  = {$urandom, $urandom};
    bus.s_rd_ready = NREQ'($urandom);
    bus.m_wr_ready = 1'($urandom);
    bus.m_wr_last  = 1'($urandom);
    bus.m_rd_vld   = 1'($urandom);
    bus.m_rd_data  = DSIZE'($urandom);
  endtask

  // Only the owner sees the master's stream, and only while a grant is active.
  task automatic check_streams(input int owner, input bit active);
    logic [NREQ-1:0] oh;
    #1;
    oh = active ? (NREQ'(1) << owner) : '0;
    check_eq("m_wr_vld",   64'(bus.m_wr_vld),   64'(active & bus.s_wr_vld[owner]));
    check_eq("m_wr_data",  64'(bus.m_wr_data),  active ? 64'(bus.s_wr_data[owner*DSIZE +: DSIZE]) : 64'(0));
    check_eq("s_wr_ready", 64'(bus.s_wr_ready), bus.m_wr_ready ? 64'(oh) : 64'(0));
    check_eq("s_wr_last",  64'(bus.s_wr_last),  bus.m_wr_last  ? 64'(oh) : 64'(0));
    check_eq("m_rd_ready", 64'(bus.m_rd_ready), 64'(active & bus.s_rd_ready[owner]));
    check_eq("s_rd_vld",   64'(bus.s_rd_vld),   bus.m_rd_vld   ? 64'(oh) : 64'(0));
    check_eq("s_rd_data",  64'(bus.s_rd_data),  active ? 64'(bus.m_rd_data) : 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s_busy"},    64'(bus.s_busy),       64'(0));
    check_eq({tag, "_s_finish"},  64'(bus.s_finish),     64'(0));
    check_eq({tag, "_m_request"}, 64'(bus.m_request),    64'(0));
    check_eq({tag, "_m_len"},     64'(bus.m_req_len),    64'(0));
    check_eq({tag, "_m_wr_len"},  64'(bus.m_req_wr_len), 64'(0));
    check_eq({tag, "_m_cmd"},     64'(bus.m_req_cmd),    64'(0));
    check_eq({tag, "_arb_err"},   64'(arb_err),          64'(0));
    check_streams(0, 1'b0);
  endtask

  // Precondition: FSM idle, s_request already driven for the decision edge.
  // path 0: finish during ISSUE; 1: busy then RUN with traffic; 2: watchdog expiry.
  // Ends in the IDLE cycle after release with next_mask driven.
  task automatic grant_and_run(input int path, input int run_len, input logic [NREQ-1:0] next_mask);
    int               exp_o;
    int               n;
    logic [LEN_W-1:0] e_len;
    logic [LEN_W-1:0] e_wr_len;
    logic [CMD_W-1:0] e_cmd;
    exp_o = model_pick(bus.s_request, exp_ptr);
    check_eq("req_pending", 64'(exp_o >= 0), 64'(1));
    if (exp_o < 0) return;
    e_len    = len_tab[exp_o];
    e_wr_len = wr_len_tab[exp_o];
    e_cmd    = cmd_tab[exp_o];
    step();
    grant_log.push_back(onehot_idx(bus.s_busy));
    check_eq("grant_busy",   64'(bus.s_busy),       64'(NREQ'(1) << exp_o));
    check_eq("grant_mreq",   64'(bus.m_request),    64'(1));
    check_eq("grant_len",    64'(bus.m_req_len),    64'(e_len));
    check_eq("grant_wr_len", 64'(bus.m_req_wr_len), 64'(e_wr_len));
    check_eq("grant_cmd",    64'(bus.m_req_cmd),    64'(e_cmd));
    check_eq("grant_finish", 64'(bus.s_finish),     64'(0));
    // New descriptors and a changed request vector must not disturb the grant.
    randomize_descs();
    bus.s_request = NREQ'($urandom);
    case (path)
      0: begin
        bus.m_finish = 1'b1;
        step();
        bus.m_finish = 1'b0;
      end
      1: begin
        n = $urandom_range(0, 2);
        repeat (n) begin
          drive_streams();
          check_streams(exp_o, 1'b1);
          step();
          check_eq("issue_hold", 64'(bus.m_request), 64'(1));
        end
        bus.m_busy = 1'b1;
        step();
        check_eq("run_mreq",    64'(bus.m_request), 64'(0));
        check_eq("run_len_lat", 64'(bus.m_req_len), 64'(e_len));
        check_eq("run_cmd_lat", 64'(bus.m_req_cmd), 64'(e_cmd));
        repeat (run_len) begin
          drive_streams();
          clk_en = ($urandom_range(0, 3) != 0);
          check_streams(exp_o, 1'b1);
          step();
          check_eq("run_busy", 64'(bus.s_busy), 64'(NREQ'(1) << exp_o));
        end
        clk_en       = 1'b1;
        bus.m_finish = 1'b1;
        step();
        bus.m_finish = 1'b0;
        bus.m_busy   = 1'b0;
      end
      default: begin
        n = 0;
        check_eq("wdog_pre_err", 64'(arb_err), 64'(0));
        while (bus.s_finish == '0 && n < int'(TIMEOUT) + 8) begin
          step();
          n++;
        end
        check_eq("wdog_cycles", 64'(n), 64'(TIMEOUT));
        check_eq("wdog_err", 64'(arb_err), 64'(1));
      end
    endcase
    check_eq("rel_finish", 64'(bus.s_finish),  64'(NREQ'(1) << exp_o));
    check_eq("rel_busy",   64'(bus.s_busy),    64'(0));
    check_eq("rel_mreq",   64'(bus.m_request), 64'(0));
    drive_streams();
    check_streams(exp_o, 1'b0);
    exp_ptr       = (exp_o + 1) % NREQ;
    bus.s_request = next_mask;
    clk_en        = 1'b1;
    step();
    check_eq("idle_finish", 64'(bus.s_finish), 64'(0));
    check_eq("idle_busy",   64'(bus.s_busy),   64'(0));
  endtask

  initial begin
    int               sz;
    int               path;
    logic [NREQ-1:0]  nxt;

    rst_n          = 1'b0;
    clk_en         = 1'b1;
    bus.s_request  = '0;
    bus.m_busy     = 1'b0;
    bus.m_finish   = 1'b0;
    randomize_descs();
    drive_streams();
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Slots 0 and 7 requesting from ptr 0: 0 first, then 7.
    bus.s_request = 8'h81;
    grant_and_run(1, 3, 8'h81);
    grant_and_run(0, 0, 8'h08);
    sz = grant_log.size();
    check_eq("order_81_a", 64'(grant_log[sz-2]), 64'(0));
    check_eq("order_81_b", 64'(grant_log[sz-1]), 64'(7));

    // Slot 3 holds its request, slot 5 joins: order 3, 5, 3.
    grant_and_run(1, 2, 8'h28);
    grant_and_run(1, 2, 8'h28);
    grant_and_run(0, 0, 8'h02);
    sz = grant_log.size();
    check_eq("order_353_a", 64'(grant_log[sz-3]), 64'(3));
    check_eq("order_353_b", 64'(grant_log[sz-2]), 64'(5));
    check_eq("order_353_c", 64'(grant_log[sz-1]), 64'(3));

    // Finish while still in ISSUE, then a full write burst for slot 1.
    grant_and_run(0, 0, 8'h02);
    grant_and_run(1, 4, 8'h40);

    // Park the pointer at 7, then reset in the middle of slot 2's transfer.
    grant_and_run(1, 1, 8'h04);
    check_eq("pre_rst_pick", 64'(model_pick(bus.s_request, exp_ptr)), 64'(2));
    step();
    check_eq("rst_grant2", 64'(bus.s_busy), 64'(8'h04));
    bus.m_busy = 1'b1;
    step();
    check_eq("rst_in_run", 64'(bus.m_request), 64'(0));
    bus.s_request = '0;
    drive_streams();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    bus.m_busy = 1'b0;
    exp_ptr    = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Pointer restarts at 0, so slot 2 wins over slot 7.
    bus.s_request = 8'h84;
    grant_and_run(1, 2, 8'h00);
    check_eq("post_rst_grant", 64'(grant_log[grant_log.size()-1]), 64'(2));

    // Randomized traffic against the model, with occasional gated idle cycles.
    bus.s_request = NREQ'($urandom_range(1, 255));
    for (int it = 0; it < 50; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        clk_en = 1'b0;
        step();
        check_eq("gated_idle", 64'(bus.s_busy), 64'(0));
        clk_en = 1'b1;
      end
      path = ($urandom_range(0, 3) == 0) ? 0 : 1;
      nxt  = NREQ'($urandom_range(1, 255));
      grant_and_run(path, $urandom_range(1, 6), nxt);
    end

`ifdef SPI_ARB_WDOG_EN
    // Master never finishes: watchdog releases slot, next requester served.
    bus.s_request = 8'h10;
    grant_and_run(2, 0, 8'h20);
    grant_and_run(0, 0, 8'h00);
    check_eq("wdog_next", 64'(grant_log[grant_log.size()-1]), 64'(5));
    check_eq("wdog_sticky", 64'(arb_err), 64'(1));
`else
    bus.s_request = '0;
    check_eq("no_wdog_err", 64'(arb_err), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
